// File: rtl/machine_timer.sv
// Memory-mapped machine timer: free-running 64-bit mtime, 64-bit mtimecmp and msip,
// driving the machine timer and software interrupt-pending levels into the CSR file.
module machine_timer #(
   parameter int TICK_DIVIDE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        bus_select,
   input  logic        bus_write,
   input  logic [2:0]  bus_address,
   input  logic [31:0] bus_write_value,
   output logic [31:0] bus_read_value,
   output logic        bus_ready,
   output logic        timer_pending,
   output logic        software_pending
);

   localparam int PRESCALE_WIDTH = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
   localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(TICK_DIVIDE - 1);

   typedef enum logic [2:0] {
      ADDR_MTIME_LO    = 3'd0,
      ADDR_MTIME_HI    = 3'd1,
      ADDR_MTIMECMP_LO = 3'd2,
      ADDR_MTIMECMP_HI = 3'd3,
      ADDR_MSIP        = 3'd4
   } addr_t;

   logic [PRESCALE_WIDTH-1:0] prescaler;
   logic [63:0]               mtime;
   logic [63:0]               mtimecmp;
   logic                      msip;
   logic                      tick;
   logic                      write_en;
   logic                      mtime_write;
   logic [31:0]               read_mux;

   assign tick        = (prescaler == PRESCALE_LAST);
   assign write_en    = bus_select & bus_write;
   assign mtime_write = write_en & ((bus_address == ADDR_MTIME_LO) |
                                    (bus_address == ADDR_MTIME_HI));

   // NOTE: every path assigns read_mux after a leading default, so no latch is inferred.
   always_comb begin
      read_mux = '0;
      case (bus_address)
         ADDR_MTIME_LO:    read_mux = mtime[31:0];
         ADDR_MTIME_HI:    read_mux = mtime[63:32];
         ADDR_MTIMECMP_LO: read_mux = mtimecmp[31:0];
         ADDR_MTIMECMP_HI: read_mux = mtimecmp[63:32];
         ADDR_MSIP:        read_mux = {31'b0, msip};
         default:          read_mux = '0;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         prescaler      <= '0;
         mtime          <= '0;
         mtimecmp       <= '1;
         msip           <= 1'b0;
         timer_pending  <= 1'b0;
         bus_ready      <= 1'b0;
         bus_read_value <= '0;
      end else begin
         prescaler <= tick ? '0 : prescaler + 1'b1;

         // A write to either mtime half replaces the increment for this edge.
         if (mtime_write) begin
            if (bus_address == ADDR_MTIME_LO) mtime[31:0]  <= bus_write_value;
            else                              mtime[63:32] <= bus_write_value;
         end else if (tick) begin
            mtime <= mtime + 64'd1;
         end

         if (write_en) begin
            case (bus_address)
               ADDR_MTIMECMP_LO: mtimecmp[31:0]  <= bus_write_value;
               ADDR_MTIMECMP_HI: mtimecmp[63:32] <= bus_write_value;
               ADDR_MSIP:        msip            <= bus_write_value[0];
               default:          ;
            endcase
         end

         timer_pending <= (mtime >= mtimecmp);

         bus_ready <= bus_select;
         if (bus_select) bus_read_value <= bus_write ? 32'd0 : read_mux;
      end
   end

   assign software_pending = msip;

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: directed bus traffic on a divide-by-1 and a
// divide-by-4 instance, with expected read data queued and checked by per-instance monitors.
module tb_machine_timer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        sel1 = 1'b0, wr1 = 1'b0;
   logic [2:0]  addr1 = '0;
   logic [31:0] wdata1 = '0, rdata1;
   logic        ready1, tp1, sp1;

   logic        sel4 = 1'b0, wr4 = 1'b0;
   logic [2:0]  addr4 = '0;
   logic [31:0] wdata4 = '0, rdata4;
   logic        ready4, tp4, sp4;

   int checks = 0;
   int failures = 0;

   logic [31:0] q1[$];
   logic [31:0] q4[$];

   machine_timer #(.TICK_DIVIDE(1)) dut (
      .clock(clock), .reset(reset),
      .bus_select(sel1), .bus_write(wr1), .bus_address(addr1),
      .bus_write_value(wdata1), .bus_read_value(rdata1), .bus_ready(ready1),
      .timer_pending(tp1), .software_pending(sp1)
   );

   machine_timer #(.TICK_DIVIDE(4)) dut4 (
      .clock(clock), .reset(reset),
      .bus_select(sel4), .bus_write(wr4), .bus_address(addr4),
      .bus_write_value(wdata4), .bus_read_value(rdata4), .bus_ready(ready4),
      .timer_pending(tp4), .software_pending(sp4)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitors: every response pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (ready1 === 1'b1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready1: got ready with no request outstanding, expected none");
         end else begin
            check("read_value1", rdata1, q1.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (ready4 === 1'b1) begin
         if (q4.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready4: got ready with no request outstanding, expected none");
         end else begin
            check("read_value4", rdata4, q4.pop_front());
         end
      end
   end

   task automatic bus_op(input bit use4, input bit write, input logic [2:0] address,
                         input logic [31:0] data, input logic [31:0] expected);
      @(negedge clock);
      if (use4) begin
         sel4 = 1'b1; wr4 = write; addr4 = address; wdata4 = data;
         q4.push_back(expected);
      end else begin
         sel1 = 1'b1; wr1 = write; addr1 = address; wdata1 = data;
         q1.push_back(expected);
      end
      @(posedge clock);
      #1;
      sel1 = 1'b0;
      sel4 = 1'b0;
   endtask

   // Optionally issues an unqueued read in the reset cycle; its response must be dropped.
   task automatic do_reset(input bit with_request);
      @(negedge clock);
      reset = 1'b1;
      if (with_request) begin
         sel1 = 1'b1; wr1 = 1'b0; addr1 = 3'd4;
      end
      @(negedge clock);
      reset = 1'b0;
      sel1  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state and free-running count
      do_reset(1'b0);
      check("reset_ready", {31'b0, ready1}, 32'd0);
      check("reset_read_value", rdata1, 32'd0);
      check("reset_timer_pending", {31'b0, tp1}, 32'd0);
      check("reset_software_pending", {31'b0, sp1}, 32'd0);
      repeat (9) @(negedge clock);
      bus_op(0, 0, 3'd0, '0, 32'd10);
      bus_op(0, 0, 3'd1, '0, 32'd0);
      check("count_timer_pending", {31'b0, tp1}, 32'd0);

      // mtime=0, mtimecmp=5 via high then low half
      bus_op(0, 1, 3'd1, 32'd0, 32'd0);
      bus_op(0, 1, 3'd0, 32'd0, 32'd0);
      bus_op(0, 1, 3'd3, 32'd0, 32'd0);
      bus_op(0, 1, 3'd2, 32'd5, 32'd0);
      repeat (4) @(negedge clock);
      check("pending_before_match", {31'b0, tp1}, 32'd0);
      @(negedge clock);
      check("pending_after_match", {31'b0, tp1}, 32'd1);
      bus_op(0, 1, 3'd2, 32'd100, 32'd0);
      check("pending_same_cycle", {31'b0, tp1}, 32'd1);
      @(negedge clock);
      @(negedge clock);
      check("pending_cleared", {31'b0, tp1}, 32'd0);
      bus_op(0, 0, 3'd3, '0, 32'd0);
      bus_op(0, 0, 3'd2, '0, 32'd100);
      @(negedge clock);
      @(negedge clock);
      check("read_value_hold", rdata1, 32'd100);
      check("ready_idle", {31'b0, ready1}, 32'd0);

      // msip and reserved offsets
      bus_op(0, 1, 3'd4, 32'd1, 32'd0);
      check("software_pending_set", {31'b0, sp1}, 32'd1);
      bus_op(0, 0, 3'd4, '0, 32'd1);
      bus_op(0, 1, 3'd4, 32'hFFFF_FFFE, 32'd0);
      check("software_pending_clear", {31'b0, sp1}, 32'd0);
      bus_op(0, 0, 3'd4, '0, 32'd0);
      bus_op(0, 1, 3'd6, 32'hDEAD_BEEF, 32'd0);
      bus_op(0, 0, 3'd6, '0, 32'd0);
      bus_op(0, 0, 3'd5, '0, 32'd0);
      bus_op(0, 0, 3'd7, '0, 32'd0);
      bus_op(0, 0, 3'd2, '0, 32'd100);

      // Carry from low to high half, then full 64-bit wrap
      bus_op(0, 1, 3'd1, 32'd0, 32'd0);
      bus_op(0, 1, 3'd0, 32'hFFFF_FFFF, 32'd0);
      @(negedge clock);
      bus_op(0, 0, 3'd0, '0, 32'd0);
      bus_op(0, 0, 3'd1, '0, 32'd1);
      bus_op(0, 1, 3'd0, 32'hFFFF_FFFF, 32'd0);
      bus_op(0, 1, 3'd1, 32'hFFFF_FFFF, 32'd0);
      @(negedge clock);
      bus_op(0, 0, 3'd1, '0, 32'd0);
      bus_op(0, 0, 3'd0, '0, 32'd1);

      // Reset mid-count with timer_pending high
      bus_op(0, 1, 3'd2, 32'd0, 32'd0);
      bus_op(0, 1, 3'd4, 32'd1, 32'd0);
      bus_op(0, 0, 3'd4, '0, 32'd1);
      @(negedge clock);
      check("pending_cmp_zero", {31'b0, tp1}, 32'd1);
      do_reset(1'b1);
      check("midreset_ready", {31'b0, ready1}, 32'd0);
      check("midreset_read_value", rdata1, 32'd0);
      check("midreset_timer_pending", {31'b0, tp1}, 32'd0);
      check("midreset_software_pending", {31'b0, sp1}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("pending_stays_low", {31'b0, tp1}, 32'd0);
      end

      // Divide-by-4 instance: ticks on the 4th, 8th, ... edge after reset
      repeat (3) @(negedge clock);
      bus_op(1, 0, 3'd0, '0, 32'd1);
      bus_op(1, 0, 3'd0, '0, 32'd2);
      bus_op(1, 0, 3'd0, '0, 32'd2);
      bus_op(1, 0, 3'd0, '0, 32'd2);
      bus_op(1, 0, 3'd0, '0, 32'd2);
      bus_op(1, 0, 3'd0, '0, 32'd3);
      @(negedge clock);
      @(negedge clock);
      bus_op(1, 1, 3'd0, 32'd1000, 32'd0);
      bus_op(1, 0, 3'd0, '0, 32'd1000);
      bus_op(1, 0, 3'd0, '0, 32'd1000);
      bus_op(1, 0, 3'd0, '0, 32'd1000);
      bus_op(1, 0, 3'd0, '0, 32'd1000);
      bus_op(1, 0, 3'd0, '0, 32'd1001);

      // Reset values of mtimecmp after the mid-count reset
      bus_op(0, 0, 3'd3, '0, 32'hFFFF_FFFF);
      bus_op(0, 0, 3'd2, '0, 32'hFFFF_FFFF);

      repeat (3) @(negedge clock);
      check("queue1_drained", 32'(q1.size()), 32'd0);
      check("queue4_drained", 32'(q4.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
